// File: rtl/fetch_align_pkg.sv
// Shared definitions for the instruction fetch/align stage.
package fetch_align_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hA000_0000;

    // Fetch FSM states
    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    // One queued instruction halfword
    typedef logic [15:0] hw_t;

    // Decoder step encodings (3 behaves like 2)
    localparam logic [1:0] STEP_NONE = 2'd0;
    localparam logic [1:0] STEP_ONE  = 2'd1;
    localparam logic [1:0] STEP_TWO  = 2'd2;

    // Number of halfwords actually retired for a decoder step value
    function automatic logic [1:0] step_count(input logic [1:0] step);
        logic [1:0] n;
        case (step)
            STEP_NONE: n = STEP_NONE;
            STEP_ONE:  n = STEP_ONE;
            default:   n = STEP_TWO;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fetch_align_hw_queue.sv
// Halfword circular buffer: up to two pushes and two pops per cycle.
// Exposes the post-edge count and instruction window so the parent can
// register its outputs without a read-after-write bubble.
module hw_queue
    import fetch_align_pkg::*;
#(
    parameter int unsigned QDEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic [1:0]              push_cnt_i,
    input  hw_t                     push_hw0_i,
    input  hw_t                     push_hw1_i,
    input  logic [1:0]              pop_cnt_i,
    output logic [$clog2(QDEPTH):0] count_next_o,
    output logic [31:0]             window_next_o
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    hw_t           mem_q [QDEPTH];
    hw_t           mem_d [QDEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Next queue contents, pointers and count; window read from the new contents
    always_comb begin
        mem_d = mem_q;
        if (push_cnt_i != 2'd0) begin
            mem_d[tail_q] = push_hw0_i;
        end
        if (push_cnt_i == 2'd2) begin
            mem_d[tail_q + PW'(1'b1)] = push_hw1_i;
        end
        tail_d = tail_q + PW'(push_cnt_i);
        if (flush_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_cnt_i);
            count_d = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
        end
        window_next_o = {mem_d[head_d + PW'(1'b1)], mem_d[head_d]};
        count_next_o  = count_d;
    end

    // Queue state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            assert (count_d <= CW'(QDEPTH));
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch/align stage: fetches aligned words, queues halfwords,
// presents a two-halfword window to the decoder and handles redirects.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int unsigned QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] memAddr,
    output logic        memReq,
    input  logic [31:0] memData,
    input  logic        memOk,
    input  logic [31:0] brPc,
    input  logic        brValid,
    input  logic [1:0]  idStepPc,
    input  logic        idStepEn,
    output logic [31:0] istrWord,
    output logic [31:0] istrPc,
    output logic        istrValid
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetchPc_q, fetchPc_d;
    logic          dropFirst_q, dropFirst_d;
    logic          memReq_q, memReq_d;
    logic [31:0]   memAddr_q, memAddr_d;
    logic [31:0]   istrPc_q, istrPc_d;
    logic [31:0]   istrWord_q;
    logic          istrValid_q;

    logic          accept;
    logic          pending;
    logic          push_en;
    logic          pop_en;
    logic [1:0]    push_cnt;
    logic [1:0]    pop_cnt;
    hw_t           push_hw0;
    hw_t           push_hw1;
    logic [CW-1:0] count_d;
    logic [31:0]   window_d;

    assign accept  = memReq_q & memOk;
    assign pending = memReq_q & ~memOk;

    // Push/retire decisions and decoder PC; a redirect overrides both
    always_comb begin
        push_en  = accept & (state_q == FETCH) & ~brValid;
        pop_en   = istrValid_q & idStepEn & ~brValid;
        push_cnt = 2'd0;
        if (push_en) begin
            push_cnt = dropFirst_q ? 2'd1 : 2'd2;
        end
        push_hw0 = dropFirst_q ? memData[31:16] : memData[15:0];
        push_hw1 = memData[31:16];
        pop_cnt  = pop_en ? step_count(idStepPc) : STEP_NONE;
        if (brValid) begin
            istrPc_d = brPc & ~32'd1;
        end else begin
            istrPc_d = istrPc_q + {29'd0, pop_cnt, 1'b0};
        end
    end

    hw_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (brValid),
        .push_cnt_i    (push_cnt),
        .push_hw0_i    (push_hw0),
        .push_hw1_i    (push_hw1),
        .pop_cnt_i     (pop_cnt),
        .count_next_o  (count_d),
        .window_next_o (window_d)
    );

    // Next FSM state and fetch address; DISCARD absorbs the stale response
    always_comb begin
        state_d     = state_q;
        fetchPc_d   = fetchPc_q;
        dropFirst_d = dropFirst_q;
        if (brValid) begin
            fetchPc_d   = brPc & ~32'd3;
            dropFirst_d = brPc[1];
            state_d     = pending ? DISCARD : FETCH;
        end else if (accept) begin
            if (state_q == FETCH) begin
                fetchPc_d   = fetchPc_q + 32'd4;
                dropFirst_d = 1'b0;
            end
            state_d = FETCH;
        end
    end

    // Memory request: hold an outstanding one, else issue when two slots are free
    always_comb begin
        memReq_d  = 1'b0;
        memAddr_d = memAddr_q;
        if (pending) begin
            memReq_d = 1'b1;
        end else if ((state_d == FETCH) && ((32'(count_d) + 32'd2) <= QDEPTH)) begin
            memReq_d  = 1'b1;
            memAddr_d = fetchPc_d;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            fetchPc_q   <= RESET_PC;
            dropFirst_q <= 1'b0;
            memReq_q    <= 1'b0;
            memAddr_q   <= RESET_PC;
            istrPc_q    <= RESET_PC;
            istrWord_q  <= '0;
            istrValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetchPc_q   <= fetchPc_d;
            dropFirst_q <= dropFirst_d;
            memReq_q    <= memReq_d;
            memAddr_q   <= memAddr_d;
            istrPc_q    <= istrPc_d;
            istrWord_q  <= window_d;
            istrValid_q <= (count_d >= CW'(2));
        end
    end

    assign memAddr   = memAddr_q;
    assign memReq    = memReq_q;
    assign istrWord  = istrWord_q;
    assign istrPc    = istrPc_q;
    assign istrValid = istrValid_q;

endmodule
